// File: rtl/bus_arbiter_mux.sv
// Registered N-source bus multiplexer with round-robin conflict resolution,
// grant locking and a saturating conflict counter.
module bus_arbiter_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 32,
  parameter int unsigned SELW  = $clog2(NSRC),
  parameter int unsigned HOLD  = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [NSRC-1:0]       src_en,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic                  lock,
  input  logic                  conflict_clr,
  output logic [WIDTH-1:0]      bus_out,
  output logic                  bus_valid,
  output logic [SELW-1:0]       src_sel,
  output logic                  conflict,
  output logic [7:0]            conflict_count
);

  logic [WIDTH-1:0] bus_q, bus_d;
  logic             valid_q, valid_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [SELW-1:0]  last_grant_q, last_grant_d;
  logic             conflict_q, conflict_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             any_req;
  logic             multi;
  logic             own_req;
  logic             found;
  logic [NSRC-1:0]  rot;
  int unsigned      start;
  int unsigned      rr_idx;
  int unsigned      grant_idx;
  logic [NSRC-1:0]  grant_oh;
  logic [WIDTH-1:0] grant_data;
  logic [SELW-1:0]  grant_sel;

  assign any_req = |src_en;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi   = |(src_en & (src_en - NSRC'(1)));
  assign own_req = src_en[last_grant_q];

  always_comb begin
    start  = 32'(last_grant_q) + 32'd1;
    // Rotate so bit 0 of rot is source last_grant+1; the doubled vector wraps mod NSRC.
    rot    = NSRC'({src_en, src_en} >> start);
    found  = 1'b0;
    rr_idx = 0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (!found && rot[i]) begin
        found  = 1'b1;
        rr_idx = start + i;
      end
    end
    if (rr_idx >= NSRC) rr_idx = rr_idx - NSRC;

    grant_idx  = (lock && valid_q && own_req) ? 32'(last_grant_q) : rr_idx;
    grant_oh   = '0;
    grant_data = '0;
    grant_sel  = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      grant_oh[i] = (grant_idx == i);
      grant_data  = grant_data | ({WIDTH{grant_oh[i]}} & src_data[i*WIDTH +: WIDTH]);
      if (grant_oh[i]) grant_sel = grant_sel | SELW'(i);
    end
  end

  always_comb begin
    bus_d        = bus_q;
    valid_d      = 1'b0;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    conflict_d   = 1'b0;
    cnt_d        = conflict_clr ? 8'd0 : cnt_q;
    if (!any_req) begin
      if (HOLD == 0) bus_d = '0;
    end else begin
      bus_d        = grant_data;
      valid_d      = 1'b1;
      sel_d        = grant_sel;
      last_grant_d = grant_sel;
      conflict_d   = multi;
    end
    if (multi && cnt_d != 8'hFF) cnt_d = cnt_d + 8'd1;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      bus_q        <= '0;
      valid_q      <= 1'b0;
      sel_q        <= '0;
      last_grant_q <= SELW'(NSRC - 1);
      conflict_q   <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      bus_q        <= bus_d;
      valid_q      <= valid_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      conflict_q   <= conflict_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus_out        = bus_q;
  assign bus_valid      = valid_q;
  assign src_sel        = sel_q;
  assign conflict       = conflict_q;
  assign conflict_count = cnt_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux: a HOLD=1 and a HOLD=0 instance with 32
// sources, plus a 24-source instance sharing the low inputs for wrap checks.
module tb_bus_arbiter_mux;

  logic          clock = 1'b0;
  logic          clear;
  logic [31:0]   src_en;
  logic [1023:0] src_data;
  logic          lock;
  logic          conflict_clr;

  logic [31:0] bus_out, bus_h0, bus24;
  logic        bus_valid, valid_h0, valid24;
  logic [4:0]  src_sel, sel_h0, sel24;
  logic        conflict, conflict_h0, conflict24;
  logic [7:0]  conflict_count, count_h0, count24;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  bus_arbiter_mux #(.WIDTH(32), .NSRC(32), .HOLD(1)) dut (
    .clock(clock), .clear(clear), .src_en(src_en), .src_data(src_data), .lock(lock),
    .conflict_clr(conflict_clr), .bus_out(bus_out), .bus_valid(bus_valid),
    .src_sel(src_sel), .conflict(conflict), .conflict_count(conflict_count)
  );

  bus_arbiter_mux #(.WIDTH(32), .NSRC(32), .HOLD(0)) dut_h0 (
    .clock(clock), .clear(clear), .src_en(src_en), .src_data(src_data), .lock(lock),
    .conflict_clr(conflict_clr), .bus_out(bus_h0), .bus_valid(valid_h0),
    .src_sel(sel_h0), .conflict(conflict_h0), .conflict_count(count_h0)
  );

  bus_arbiter_mux #(.WIDTH(32), .NSRC(24), .HOLD(1)) dut24 (
    .clock(clock), .clear(clear), .src_en(src_en[23:0]), .src_data(src_data[767:0]),
    .lock(lock), .conflict_clr(conflict_clr), .bus_out(bus24), .bus_valid(valid24),
    .src_sel(sel24), .conflict(conflict24), .conflict_count(count24)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    #1;
    clear = 1'b1;
  endtask

  task automatic test_reset();
    vectors++;
    if (bus_out !== 32'h0 || bus_valid !== 1'b0 || src_sel !== 5'd0 || conflict !== 1'b0 ||
        conflict_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_init got bus=%h v=%b sel=%0d c=%b cnt=%0d want all zero",
               bus_out, bus_valid, src_sel, conflict, conflict_count);
    end
    clear = 1'b1;
    src_en = 32'h1 << 5;
    src_data[5*32 +: 32] = 32'hDEADBEEF;
    repeat (3) step();
    vectors++;
    if (bus_out !== 32'hDEADBEEF || src_sel !== 5'd5 || bus_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_preload got bus=%h sel=%0d v=%b want deadbeef 5 1",
               bus_out, src_sel, bus_valid);
    end
    #2 clear = 1'b0;
    #1;
    vectors++;
    if (bus_out !== 32'h0 || bus_valid !== 1'b0 || src_sel !== 5'd0 || conflict !== 1'b0 ||
        conflict_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_async got bus=%h v=%b sel=%0d c=%b cnt=%0d want all zero",
               bus_out, bus_valid, src_sel, conflict, conflict_count);
    end
    #1 clear = 1'b1;
    src_en = 32'h1;
    src_data[31:0] = 32'h1;
    step();
    vectors++;
    if (bus_out !== 32'h1 || src_sel !== 5'd0 || bus_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release got bus=%h sel=%0d v=%b want 1 0 1", bus_out, src_sel,
               bus_valid);
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 32; i++) begin
      src_en = 32'h1 << i;
      src_data[i*32 +: 32] = i * 32'h01010101;
      step();
      vectors++;
      if (bus_out !== i * 32'h01010101 || src_sel !== 5'(i) || bus_valid !== 1'b1 ||
          conflict !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep[%0d] got bus=%h sel=%0d v=%b c=%b want %h %0d 1 0", i, bus_out,
                 src_sel, bus_valid, conflict, i * 32'h01010101, i);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [4:0]  exp_sel [6];
    logic [31:0] exp_bus;
    exp_sel = '{5'd3, 5'd7, 5'd30, 5'd3, 5'd7, 5'd30};
    src_data[3*32 +: 32]  = 32'hA0000003;
    src_data[7*32 +: 32]  = 32'hA0000007;
    src_data[30*32 +: 32] = 32'hA000001E;
    src_en = 32'h0;
    lock = 1'b0;
    do_reset();
    src_en = (32'h1 << 3) | (32'h1 << 7) | (32'h1 << 30);
    for (int k = 0; k < 6; k++) begin
      step();
      exp_bus = 32'hA0000000 | 32'(exp_sel[k]);
      vectors++;
      if (src_sel !== exp_sel[k] || bus_out !== exp_bus || conflict !== 1'b1 ||
          conflict_count !== 8'(k + 1)) begin
        miscompares++;
        $display("FAIL rr[%0d] got sel=%0d bus=%h c=%b cnt=%0d want %0d %h 1 %0d", k, src_sel,
                 bus_out, conflict, conflict_count, exp_sel[k], exp_bus, k + 1);
      end
    end
  endtask

  task automatic test_lock();
    src_en = 32'h0;
    lock = 1'b0;
    do_reset();
    src_en = 32'h1 << 7;
    step();
    lock = 1'b1;
    src_en = (32'h1 << 7) | (32'h1 << 9);
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if (src_sel !== 5'd7 || conflict !== 1'b1) begin
        miscompares++;
        $display("FAIL lock_hold[%0d] got sel=%0d c=%b want 7 1", k, src_sel, conflict);
      end
    end
    src_en = 32'h1 << 9;
    step();
    vectors++;
    if (src_sel !== 5'd9) begin
      miscompares++;
      $display("FAIL lock_drop got sel=%0d want 9", src_sel);
    end
    lock = 1'b0;
    src_en = 32'h1 << 7;
    step();
    lock = 1'b1;
    src_en = (32'h1 << 3) | (32'h1 << 7);
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++;
      if (src_sel !== 5'd7) begin
        miscompares++;
        $display("FAIL lock_3_7[%0d] got sel=%0d want 7", k, src_sel);
      end
    end
    lock = 1'b0;
    step();
    vectors++;
    if (src_sel !== 5'd3) begin
      miscompares++;
      $display("FAIL unlock_rr got sel=%0d want 3", src_sel);
    end
  endtask

  task automatic test_idle();
    lock = 1'b0;
    src_en = 32'h1 << 2;
    src_data[2*32 +: 32] = 32'hCAFEF00D;
    step();
    vectors++;
    if (bus_out !== 32'hCAFEF00D || bus_h0 !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL idle_grant got h1=%h h0=%h want cafef00d", bus_out, bus_h0);
    end
    src_en = 32'h0;
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++;
      if (bus_out !== 32'hCAFEF00D || bus_valid !== 1'b0 || src_sel !== 5'd2 ||
          conflict !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_hold1[%0d] got bus=%h v=%b sel=%0d c=%b want cafef00d 0 2 0", k,
                 bus_out, bus_valid, src_sel, conflict);
      end
      vectors++;
      if (bus_h0 !== 32'h0 || valid_h0 !== 1'b0 || sel_h0 !== 5'd2) begin
        miscompares++;
        $display("FAIL idle_hold0[%0d] got bus=%h v=%b sel=%0d want 0 0 2", k, bus_h0,
                 valid_h0, sel_h0);
      end
    end
  endtask

  task automatic test_counter();
    src_en = 32'h0;
    do_reset();
    src_en = (32'h1 << 1) | (32'h1 << 2);
    for (int k = 1; k <= 300; k++) begin
      step();
      if (k == 255 || k == 300) begin
        vectors++;
        if (conflict_count !== 8'd255 || conflict !== 1'b1) begin
          miscompares++;
          $display("FAIL sat[%0d] got cnt=%0d c=%b want 255 1", k, conflict_count, conflict);
        end
      end
    end
    conflict_clr = 1'b1;
    step();
    vectors++;
    if (conflict_count !== 8'd1) begin
      miscompares++;
      $display("FAIL clr_conflict got cnt=%0d want 1", conflict_count);
    end
    src_en = 32'h0;
    step();
    vectors++;
    if (conflict_count !== 8'd0 || conflict !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_idle got cnt=%0d c=%b want 0 0", conflict_count, conflict);
    end
    conflict_clr = 1'b0;
  endtask

  task automatic test_wrap24();
    logic [4:0]  exp_sel [4];
    logic [31:0] exp_bus;
    exp_sel = '{5'd23, 5'd0, 5'd23, 5'd0};
    src_data[23*32 +: 32] = 32'h23232323;
    src_data[31:0]        = 32'h00000A0A;
    src_en = 32'h0;
    do_reset();
    src_en = 32'h1 << 23;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_bus = (exp_sel[k] == 5'd23) ? 32'h23232323 : 32'h00000A0A;
      vectors++;
      if (sel24 !== exp_sel[k] || bus24 !== exp_bus || valid24 !== 1'b1) begin
        miscompares++;
        $display("FAIL wrap24[%0d] got sel=%0d bus=%h v=%b want %0d %h 1", k, sel24, bus24,
                 valid24, exp_sel[k], exp_bus);
      end
      src_en = (32'h1 << 23) | 32'h1;
    end
    vectors++;
    if (count24 !== 8'd3) begin
      miscompares++;
      $display("FAIL wrap24_cnt got cnt=%0d want 3", count24);
    end
  endtask

  initial begin
    clear = 1'b0;
    src_en = '0;
    src_data = '0;
    lock = 1'b0;
    conflict_clr = 1'b0;
    #1;
    test_reset();
    test_sweep();
    test_round_robin();
    test_lock();
    test_idle();
    test_counter();
    test_wrap24();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_mux.md
# bus_arbiter_mux

Parametrised, registered successor to the CPU datapath bus encoder/multiplexer. Each cycle it selects one of NSRC source words onto a WIDTH-bit bus from per-source "out" enables, such as R0out..R15out, HIout, LOout, ZHIout, ZLOout, PCout, MDRout, InPortout, Cout and Yout. Unlike a plain encoder/mux, it:
- registers the bus;
- detects multi-driver conflicts and resolves them round-robin;
- can lock a grant across conflicting cycles;
- counts conflicts for debug.

## Interface
Parameters:
- WIDTH, 32, bus word width in bits.
- NSRC, 32, number of sources (2..64).
- SELW, $clog2(NSRC), width of the encoded select (derived; do not override).
- HOLD, 1, idle behaviour: 1 holds the last bus value when idle; 0 drives zeros when idle.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- clear  in  1  asynchronous, active-low reset.
- src_en  in  NSRC  per-source drive enable; bit i = source i requests the bus.
- src_data  in  NSRC*WIDTH  flattened source words; source i occupies bits [i*WIDTH +: WIDTH].
- lock  in  1  holds the current grant through conflicts while its owner keeps requesting.
- conflict_clr  in  1  synchronous clear of conflict_count.
- bus_out  out  WIDTH  registered bus value.
- bus_valid  out  1  bus_out was driven by a granted source this cycle.
- src_sel  out  SELW  index of the source that produced bus_out.
- conflict  out  1  the previous cycle had more than one src_en bit set.
- conflict_count  out  8  saturating count of conflict cycles.

## Operation
Internal state is last_grant (SELW bits), the index of the most recent grant.

Each rising edge, src_en is evaluated as follows:
- Idle (src_en == 0):
  - bus_valid <= 0 and conflict <= 0.
  - bus_out <= bus_out when HOLD=1, or 0 when HOLD=0.
  - src_sel and last_grant hold.
- Single request (exactly one bit i set):
  - Grant i: bus_out <= src_data[i], bus_valid <= 1, src_sel <= i, last_grant <= i.
  - conflict <= 0.
  - lock has no effect.
- Multiple requests (two or more bits set):
  - conflict <= 1.
  - conflict_count increments, saturating at 255.
  - If lock=1, bus_valid=1 and src_en[last_grant]=1, the grant stays on last_grant.
  - Otherwise grant the first set bit found scanning last_grant+1, last_grant+2, … modulo NSRC (round-robin).
  - Granted source k: bus_out <= src_data[k], bus_valid <= 1, src_sel <= k, last_grant <= k.
- conflict_clr: conflict_count <= 0. If the same cycle is a conflict cycle, conflict_count <= 1 (clear first, then increment).

Bits of src_en at or above NSRC do not exist. Indices wrap modulo NSRC, not modulo 2^SELW, even when NSRC is not a power of two.

Combinational path: a priority-rotated one-hot select, then an AND-OR mux. No tri-states and no latches.

## Timing
- Latency is one cycle: enables and data sampled at edge n appear on bus_out/src_sel/bus_valid/conflict after edge n.
- Back-to-back grants to different sources are allowed every cycle. There are no bubbles.
- Reset (clear=0, asynchronous, effective immediately, including mid-transfer):
  - bus_out=0, bus_valid=0, src_sel=0, conflict=0, conflict_count=0.
  - last_grant=NSRC-1, so the first round-robin scan starts at source 0.
- Release of clear is synchronous to clock. The first edge with clear=1 performs a normal evaluation.
- src_data only needs to be stable around the sampling edge. The output is glitch-free because it is registered.

## Test plan
- Reset mid-operation: drive src_en=1<<5, src_data[5]=32'hDEADBEEF for 3 cycles, then pulse clear low between edges.
  - Outputs go to 0 immediately, with no clock edge.
  - After release, src_en=1<<0, src_data[0]=32'h1 -> bus_out=1, src_sel=0 one cycle later.
- Single source sweep: for i=0..NSRC-1 set src_en=1<<i, src_data[i]=i*32'h01010101.
  - Each next cycle: bus_out=i*32'h01010101, src_sel=i, bus_valid=1, conflict=0.
- Round-robin on conflict: from reset hold src_en=(1<<3)|(1<<7)|(1<<30) with lock=0.
  - Grants cycle 3, 7, 30, 3, 7, …
  - conflict=1 every cycle; conflict_count counts 1, 2, 3, ….
- Lock: grant source 7 (single request), then src_en=(1<<7)|(1<<9) with lock=1 for 4 cycles.
  - src_sel stays 7 for those 4 cycles.
  - Drop bit 7 while lock=1 -> src_sel=9.
  - lock=1 with src_en=(1<<3)|(1<<7) -> grant stays 7.
- Idle/HOLD: with HOLD=1, after a grant of 32'hCAFEF00D set src_en=0 -> bus_out stays 32'hCAFEF00D, bus_valid=0. Repeat with HOLD=0 -> bus_out=0.
- Counter saturation/clear: sustain conflicts for 300 cycles -> conflict_count=255.
  - Assert conflict_clr during a conflict cycle -> 1.
  - Assert conflict_clr during an idle cycle -> 0.
  - NSRC=24 instance: conflicts on sources 23 and 0 wrap correctly: 23, 0, 23.
